// File: rtl/hdc_fp_pkg.sv
// hdc_fp_pkg: shared fp16 types, constants and helpers for the argmax stream.
//   fp16_t         : IEEE-754 binary16 split into sign/exp/mant
//   argmax_state_t : frame state (ACCUM collects scores, HOLD presents result)
//   is_nan()       : exponent all ones with a non-zero mantissa
package hdc_fp_pkg;

   typedef struct packed {
      logic       sign;
      logic [4:0] exp;
      logic [9:0] mant;
   } fp16_t;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } argmax_state_t;

   localparam int          FP16_EXP_MAX  = 31;
   localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
   localparam logic [15:0] FP16_NEG_ZERO = 16'h8000;

   function automatic logic is_nan(input fp16_t v);
      return (v.exp == 5'(FP16_EXP_MAX)) && (v.mant != 10'd0);
   endfunction

endpackage

// File: rtl/fp16_cmp.sv
// fp16_cmp: combinational fp16 comparator in IEEE total order, except that
// +0 and -0 compare equal.
//   a, b   : binary16 operands
//   a_gt_b : a orders strictly above b (meaningless if either is NaN)
//   a_eq_b : a and b order equal
//   a_nan  : a is NaN
//   b_nan  : b is NaN
module fp16_cmp
   import hdc_fp_pkg::*;
(
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        a_gt_b,
   output logic        a_eq_b,
   output logic        a_nan,
   output logic        b_nan
);

   // Map sign-magnitude onto an unsigned key: positives above negatives,
   // negatives bit-inverted so larger magnitude sorts lower. -0 folds onto +0.
   function automatic logic [15:0] order_key(input logic [15:0] v);
      logic [15:0] z;
      z = (v == FP16_NEG_ZERO) ? FP16_POS_ZERO : v;
      return z[15] ? ~z : {1'b1, z[14:0]};
   endfunction

   logic [15:0] ka, kb;

   assign ka     = order_key(a);
   assign kb     = order_key(b);
   assign a_gt_b = ka > kb;
   assign a_eq_b = ka == kb;
   assign a_nan  = is_nan(fp16_t'(a));
   assign b_nan  = is_nan(fp16_t'(b));

endmodule

// File: rtl/fp16_argmax_stream.sv
// fp16_argmax_stream: streams NUM_CLASSES fp16 scores per frame and reports
// the index/value of the best one (max, or min when FIND_MIN=1).
//   clk, rst_n          : clock, synchronous active-low reset
//   abort               : discard the current frame / held result
//   in_valid/in_ready   : score handshake, in_score is the binary16 score
//   out_valid/out_ready : result handshake
//   out_idx/out_score   : winning arrival index and its score
//   out_nan             : the frame contained at least one NaN
module fp16_argmax_stream
   import hdc_fp_pkg::*;
#(
   parameter  int NUM_CLASSES = 10,
   parameter  int FIND_MIN    = 0,
   localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             abort,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_score,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic [15:0]      out_score,
   output logic             out_nan
);

   argmax_state_t    state;
   logic [IDX_W-1:0] cnt;
   logic [15:0]      best_score;
   logic [IDX_W-1:0] best_idx;
   logic             nan_flag;

   logic a_gt_b, a_eq_b, a_nan, b_nan;
   logic first, last, better, take, accept;
   logic [15:0]      nxt_score;
   logic [IDX_W-1:0] nxt_idx;
   logic             nxt_nan;

   fp16_cmp u_cmp (
      .a      (in_score),
      .b      (best_score),
      .a_gt_b (a_gt_b),
      .a_eq_b (a_eq_b),
      .a_nan  (a_nan),
      .b_nan  (b_nan)
   );

   // in_ready is gated by rst_n so it reads 0 for the whole reset window.
   assign in_ready = rst_n && (state == ACCUM);
   assign accept   = in_valid && in_ready;
   assign first    = (cnt == '0);
   assign last     = (cnt == IDX_W'(NUM_CLASSES - 1));

   // Strictly better only; ties keep the earlier index.
   assign better = (FIND_MIN != 0) ? (!a_gt_b && !a_eq_b) : a_gt_b;

   // A NaN held as best (frame started with NaN) yields to the first real score.
   assign take      = first || (!a_nan && (b_nan || better));
   assign nxt_score = take ? in_score : best_score;
   assign nxt_idx   = first ? '0 : (take ? cnt : best_idx);
   assign nxt_nan   = (first ? 1'b0 : nan_flag) | a_nan;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ACCUM;
         cnt        <= '0;
         best_score <= FP16_POS_ZERO;
         best_idx   <= '0;
         nan_flag   <= 1'b0;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_score  <= FP16_POS_ZERO;
         out_nan    <= 1'b0;
      end else if (abort) begin
         state     <= ACCUM;
         cnt       <= '0;
         nan_flag  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  best_score <= nxt_score;
                  best_idx   <= nxt_idx;
                  nan_flag   <= nxt_nan;
                  if (last) begin
                     cnt       <= '0;
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     out_idx   <= nxt_idx;
                     out_score <= nxt_score;
                     out_nan   <= nxt_nan;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= ACCUM;
                  out_valid <= 1'b0;
                  nan_flag  <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_argmax_stream.sv
// tb_fp16_argmax_stream: drives one argmax and one argmin instance (NUM_CLASSES=4)
// with the same stream and checks both against a real-valued reference model.
module tb_fp16_argmax_stream;

   localparam int N = 4;
   typedef logic [15:0] frame_t [N];

   logic        clk = 1'b0;
   logic        rst_n, abort, in_valid, out_ready;
   logic [15:0] in_score;
   logic        ir_max, ir_min, ov_max, ov_min, nan_max, nan_min;
   logic [1:0]  idx_max, idx_min;
   logic [15:0] sc_max, sc_min;

   int checks = 0;
   int errors = 0;
   frame_t fq[$];

   always #5 clk = ~clk;

   fp16_argmax_stream #(.NUM_CLASSES(N), .FIND_MIN(0)) dut_max (
      .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(ir_max),
      .in_score(in_score), .out_valid(ov_max), .out_ready(out_ready),
      .out_idx(idx_max), .out_score(sc_max), .out_nan(nan_max));

   fp16_argmax_stream #(.NUM_CLASSES(N), .FIND_MIN(1)) dut_min (
      .clk(clk), .rst_n(rst_n), .abort(abort), .in_valid(in_valid), .in_ready(ir_min),
      .in_score(in_score), .out_valid(ov_min), .out_ready(out_ready),
      .out_idx(idx_min), .out_score(sc_min), .out_nan(nan_min));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit isn(input logic [15:0] v);
      return (v[14:10] == 5'h1f) && (v[9:0] != 10'd0);
   endfunction

   // Numeric value of a non-NaN fp16; infinities become a value beyond fp16 range.
   function automatic real f2r(input logic [15:0] v);
      int  e, sh;
      real r;
      e = int'(v[14:10]);
      if (e == 31) r = 1.0e9;
      else begin
         r  = (e == 0) ? real'(int'(v[9:0])) : real'(1024 + int'(v[9:0]));
         sh = (e == 0) ? -24 : e - 25;
         for (int i = 0; i < sh; i++) r = r * 2.0;
         for (int i = 0; i > sh; i--) r = r / 2.0;
      end
      return v[15] ? -r : r;
   endfunction

   task automatic ref_model(input frame_t f, input bit fmin,
                            output int idx, output logic [15:0] sc, output bit nan);
      idx = 0; sc = f[0]; nan = isn(f[0]);
      for (int i = 1; i < N; i++) begin
         if (isn(f[i])) nan = 1;
         else if (isn(sc) || (fmin ? (f2r(f[i]) < f2r(sc)) : (f2r(f[i]) > f2r(sc)))) begin
            sc = f[i]; idx = i;
         end
      end
   endtask

   task automatic chk_res(input string tag, input frame_t f);
      int i0, i1; logic [15:0] s0, s1; bit n0, n1;
      ref_model(f, 0, i0, s0, n0);
      ref_model(f, 1, i1, s1, n1);
      chk({tag, "_vmax"}, ov_max, 1);   chk({tag, "_vmin"}, ov_min, 1);
      chk({tag, "_imax"}, idx_max, i0); chk({tag, "_imin"}, idx_min, i1);
      chk({tag, "_smax"}, sc_max, s0);  chk({tag, "_smin"}, sc_min, s1);
      chk({tag, "_nmax"}, nan_max, n0); chk({tag, "_nmin"}, nan_min, n1);
   endtask

   function automatic logic [15:0] rnd_score();
      logic [15:0] sp [8];
      sp = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h0001, 16'h8001, 16'h3C00};
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 7)];
      return 16'($urandom());
   endfunction

   // Present one score and wait (bounded) for it to be accepted; returns #1 after that edge.
   task automatic send(input logic [15:0] s);
      bit ok; int n;
      in_valid = 1; in_score = s; n = 0;
      do begin
         @(negedge clk); ok = ir_max;
         @(posedge clk); #1; n++;
      end while (!ok && n < 20);
      if (!ok) chk("send_timeout", 0, 1);
      in_valid = 0;
   endtask

   // Continuous stream of frames from fq; the next frame's first score is
   // presented during HOLD so back-to-back acceptance is exercised.
   task automatic run_stream(input int nfr, input int gap_pct);
      int fi = 0, si = 0, hold_left = 0, guard = 0, cur;
      bit holding = 0, ir;
      out_ready = 0;
      in_valid  = 1; in_score = fq[0][0];
      while (fi < nfr && guard < 5000) begin
         guard++;
         @(negedge clk);
         ir = ir_max;
         chk("in_ready_max", ir, !holding);
         chk("in_ready_min", ir_min, !holding);
         @(posedge clk); #1;
         if (holding) begin
            if (out_ready) begin
               holding = 0; fi++;
               chk("ov_drop", ov_max, 0);
            end else chk_res("hold", fq[fi]);
         end else if (in_valid && ir) begin
            si++;
            if (si == N) begin
               si = 0; holding = 1;
               chk_res("result", fq[fi]);
               hold_left = (fi == 0) ? 5 : $urandom_range(0, 3);
            end else chk("ov_accum", ov_max, 0);
         end else chk("ov_idle", ov_max, 0);
         cur = holding ? fi + 1 : fi;
         in_score  = (cur < nfr) ? fq[cur][si] : 16'h0;
         in_valid  = (cur < nfr) && ($urandom_range(0, 99) >= gap_pct);
         out_ready = holding && (hold_left == 0);
         if (holding && hold_left > 0) hold_left--;
      end
      if (fi < nfr) chk("stream_timeout", 0, 1);
      in_valid = 0; out_ready = 0;
   endtask

   initial begin
      frame_t f;
      rst_n = 0; abort = 0; in_valid = 1; in_score = 16'h4000; out_ready = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", ir_max, 0);
      chk("rst_out_valid", ov_max, 0);
      chk("rst_out_idx", idx_max, 0);
      chk("rst_out_score", sc_max, 16'h0000);
      chk("rst_out_nan", nan_max, 0);
      in_valid = 0;
      rst_n = 1; #1;
      chk("rel_in_ready", ir_max, 1);

      fq.push_back('{16'h3C00, 16'h4000, 16'hBC00, 16'h3C00});
      fq.push_back('{16'h8000, 16'h0000, 16'hC000, 16'h8000});
      fq.push_back('{16'h7E00, 16'h3C00, 16'h7C00, 16'h7E00});
      fq.push_back('{16'h7E00, 16'hFC01, 16'h7C01, 16'h7E00});
      fq.push_back('{16'h4000, 16'hC000, 16'hBC00, 16'hC000});
      for (int k = 0; k < 40; k++) begin
         for (int j = 0; j < N; j++) f[j] = rnd_score();
         fq.push_back(f);
      end
      @(posedge clk); #1;
      run_stream(fq.size(), 20);

      // Close out any held result so the abort sequence starts from ACCUM.
      out_ready = 1; @(posedge clk); #1; out_ready = 0;

      // Abort after two accepts; a score offered with abort must be dropped.
      send(rnd_score()); send(rnd_score());
      abort = 1; in_valid = 1; in_score = 16'h7C00;
      @(posedge clk); #1;
      abort = 0; in_valid = 0;
      chk("abort_ov", ov_max, 0);
      f = '{16'h3555, 16'hB800, 16'h5000, 16'h1234};
      for (int j = 0; j < N; j++) send(f[j]);
      chk_res("post_abort", f);

      // Reset while holding: result vanishes, everything back to reset values.
      rst_n = 0; @(posedge clk); #1;
      chk("rst_hold_ov", ov_max, 0);
      chk("rst_hold_ir", ir_max, 0);
      chk("rst_hold_idx", idx_max, 0);
      chk("rst_hold_sc", sc_max, 16'h0000);
      chk("rst_hold_nan", nan_max, 0);
      rst_n = 1; #1;
      chk("rst_rel_ir", ir_max, 1);
      f = '{16'hFE00, 16'h0400, 16'h83FF, 16'h0400};
      for (int j = 0; j < N; j++) send(f[j]);
      chk_res("post_reset", f);

      // Abort during HOLD drops the result and reopens the input.
      abort = 1; @(posedge clk); #1; abort = 0;
      chk("abort_hold_ov", ov_max, 0);
      chk("abort_hold_ir", ir_max, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
